// File: rtl/io_bus_ctrl_if.sv
// Core IO bus, UART TX/RX links and register observation
// outputs of the memory-mapped IO controller.
interface io_bus_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              io_we;
    logic              io_re;
    logic [ADDR_W-1:0] io_addr;
    logic [31:0]       io_wdata;
    logic [31:0]       io_rdata;
    logic              io_rvalid;
    logic              io_stall;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [31:0]       io_uart_io_reg;
    logic [31:0]       io_uart_csr_reg;
    logic [31:0]       io_gpio_io_reg;

    modport slave (
        input  io_we, io_re, io_addr, io_wdata,
        input  tx_ready, rx_data, rx_valid,
        output io_rdata, io_rvalid, io_stall,
        output tx_data, tx_valid,
        output io_uart_io_reg, io_uart_csr_reg, io_gpio_io_reg
    );

    modport master (
        output io_we, io_re, io_addr, io_wdata,
        output tx_ready, rx_data, rx_valid,
        input  io_rdata, io_rvalid, io_stall,
        input  tx_data, tx_valid,
        input  io_uart_io_reg, io_uart_csr_reg, io_gpio_io_reg
    );
endinterface

// File: rtl/io_bus_ctrl.sv
// Memory-mapped IO controller: UART TX FIFO + sequencer,
// UART RX latch, CSR and GPIO registers.
module io_bus_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 8
) (
    input  logic          clk,
    input  logic          rst,
    io_bus_ctrl_if.slave  bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [ADDR_W-1:0] A_UIO  = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_CSR  = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] A_GPIO = ADDR_W'(8);

    typedef enum logic {IDLE, SEND} state_e;

    state_e          state_q, state_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      txd_q, txd_d;
    logic [7:0]      rxb_q, rxb_d;
    logic            rxf_q, rxf_d;
    logic            ovr_q, ovr_d;
    logic [31:0]     gpio_q, gpio_d;
    logic [7:0]      uio_q, uio_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            rvalid_q;

    logic sel_uio, sel_csr, sel_gpio;
    logic wr, rd, rd_uio;
    logic full, empty, push, pop;
    logic busy;
    logic [31:0] csr;

    assign sel_uio  = bus.io_addr == A_UIO;
    assign sel_csr  = bus.io_addr == A_CSR;
    assign sel_gpio = bus.io_addr == A_GPIO;

    // A simultaneous write drops the read entirely
    assign wr     = bus.io_we;
    assign rd     = bus.io_re && !bus.io_we;
    assign rd_uio = rd && sel_uio;

    assign full  = cnt_q == CW'(FIFO_DEPTH);
    assign empty = cnt_q == '0;
    assign push  = wr && sel_uio && !full;
    assign pop   = (state_q == IDLE) && !empty;

    assign bus.io_stall = wr && sel_uio && full;

    // FIFO pointers and occupancy
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push) wptr_d = wptr_q + 1'b1;
        if (pop)  rptr_d = rptr_q + 1'b1;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= bus.io_wdata[7:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (!empty) state_d = SEND;
            SEND:    if (bus.tx_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy  = 1'b0;
        txd_d = txd_q;
        unique case (state_q)
            IDLE:    if (pop) txd_d = mem_q[rptr_q];
            SEND:    busy = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    assign bus.tx_valid = busy;
    assign bus.tx_data  = txd_q;

    // A read racing a new byte returns the old one and keeps rx_full
    always_comb begin
        rxb_d = rxb_q;
        rxf_d = rxf_q;
        ovr_d = ovr_q;
        if (wr && sel_csr && bus.io_wdata[3]) ovr_d = 1'b0;
        if (bus.rx_valid) begin
            if (!rxf_q || rd_uio) begin
                rxb_d = bus.rx_data;
                rxf_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (rd_uio) begin
            rxf_d = 1'b0;
        end
    end

    always_comb begin
        csr         = '0;
        csr[0]      = empty;
        csr[1]      = full;
        csr[2]      = rxf_q;
        csr[3]      = ovr_q;
        csr[4 +: CW] = cnt_q;
        csr[7]      = busy;
    end

    always_comb begin
        gpio_d = gpio_q;
        uio_d  = uio_q;
        if (wr && sel_gpio) gpio_d = bus.io_wdata;
        if (push)           uio_d  = bus.io_wdata[7:0];
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rd) begin
            unique case (1'b1)
                sel_uio:  rdata_d = {24'b0, rxb_q};
                sel_csr:  rdata_d = csr;
                sel_gpio: rdata_d = gpio_q;
                default:  rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            txd_q    <= '0;
            rxb_q    <= '0;
            rxf_q    <= 1'b0;
            ovr_q    <= 1'b0;
            gpio_q   <= '0;
            uio_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            txd_q    <= txd_d;
            rxb_q    <= rxb_d;
            rxf_q    <= rxf_d;
            ovr_q    <= ovr_d;
            gpio_q   <= gpio_d;
            uio_q    <= uio_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rd;
        end
    end

    assign bus.io_rdata        = rdata_q;
    assign bus.io_rvalid       = rvalid_q;
    assign bus.io_uart_io_reg  = {24'b0, uio_q};
    assign bus.io_uart_csr_reg = csr;
    assign bus.io_gpio_io_reg  = gpio_q;
endmodule

// File: tb/tb_io_bus_ctrl.sv
// Directed vector bench for io_bus_ctrl: table of bus cycles
// plus hand sequences for FIFO backpressure and reset mid-send.
module tb_io_bus_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    io_bus_ctrl_if #(.ADDR_W(8)) ifc ();

    io_bus_ctrl #(.FIFO_DEPTH(4), .ADDR_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    typedef struct {
        logic        we;
        logic        re;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic        rxv;
        logic [7:0]  rxd;
        logic        txr;
        logic        e_stall;
        logic        e_rvalid;
        logic [31:0] e_rdata;
        logic        e_txv;
        logic [7:0]  e_txd;
        logic [31:0] e_csr;
        logic [31:0] e_gpio;
        logic [7:0]  e_uio;
    } vec_t;

    int ncmp = 0;
    int nfail = 0;
    logic [7:0] txq [$];

    always @(posedge clk)
        if (ifc.tx_valid && ifc.tx_ready) txq.push_back(ifc.tx_data);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic we, input logic re, input logic [7:0] addr,
        input logic [31:0] wdata, input logic rxv, input logic [7:0] rxd,
        input logic txr, input logic st, input logic rv,
        input logic [31:0] rdat, input logic txv, input logic [7:0] txd,
        input logic [31:0] csr, input logic [31:0] gpio, input logic [7:0] uio);
        vec_t v;
        v.we = we; v.re = re; v.addr = addr; v.wdata = wdata;
        v.rxv = rxv; v.rxd = rxd; v.txr = txr;
        v.e_stall = st; v.e_rvalid = rv; v.e_rdata = rdat;
        v.e_txv = txv; v.e_txd = txd; v.e_csr = csr;
        v.e_gpio = gpio; v.e_uio = uio;
        return v;
    endfunction

    task automatic idle_in();
        ifc.io_we = 0; ifc.io_re = 0; ifc.io_addr = 0; ifc.io_wdata = 0;
        ifc.rx_valid = 0; ifc.rx_data = 0;
    endtask

    task automatic wr_byte(input logic [7:0] b);
        ifc.io_we = 1; ifc.io_addr = 8'h00; ifc.io_wdata = {24'h0, b};
        @(negedge clk);
    endtask

    vec_t tbl [21];
    logic [7:0] exp3 [6];
    bit done;

    initial begin
        tbl[0]  = mk(0,1,8'h04,0,0,0,1, 0,1,32'h1,0,0,32'h01,0,0);
        tbl[1]  = mk(1,0,8'h08,32'hDEADBEEF,0,0,1, 0,0,0,0,0,32'h01,32'hDEADBEEF,0);
        tbl[2]  = mk(0,1,8'h08,0,0,0,1, 0,1,32'hDEADBEEF,0,0,32'h01,32'hDEADBEEF,0);
        tbl[3]  = mk(0,0,8'h00,0,0,0,1, 0,0,0,0,0,32'h01,32'hDEADBEEF,0);
        tbl[4]  = mk(1,0,8'h00,32'h41,0,0,1, 0,0,0,0,0,32'h10,32'hDEADBEEF,8'h41);
        tbl[5]  = mk(1,0,8'h00,32'h42,0,0,1, 0,0,0,1,8'h41,32'h90,32'hDEADBEEF,8'h42);
        tbl[6]  = mk(1,0,8'h00,32'h43,0,0,1, 0,0,0,0,0,32'h20,32'hDEADBEEF,8'h43);
        tbl[7]  = mk(0,0,8'h00,0,0,0,1, 0,0,0,1,8'h42,32'h90,32'hDEADBEEF,8'h43);
        tbl[8]  = mk(0,0,8'h00,0,0,0,1, 0,0,0,0,0,32'h10,32'hDEADBEEF,8'h43);
        tbl[9]  = mk(0,0,8'h00,0,0,0,1, 0,0,0,1,8'h43,32'h81,32'hDEADBEEF,8'h43);
        tbl[10] = mk(0,0,8'h00,0,0,0,1, 0,0,0,0,0,32'h01,32'hDEADBEEF,8'h43);
        tbl[11] = mk(1,1,8'h08,32'h12345678,0,0,1, 0,0,0,0,0,32'h01,32'h12345678,8'h43);
        tbl[12] = mk(0,1,8'h10,0,0,0,1, 0,1,32'h0,0,0,32'h01,32'h12345678,8'h43);
        tbl[13] = mk(0,1,8'h0C,0,0,0,1, 0,1,32'h0,0,0,32'h01,32'h12345678,8'h43);
        tbl[14] = mk(0,0,8'h00,0,1,8'h55,1, 0,0,0,0,0,32'h05,32'h12345678,8'h43);
        tbl[15] = mk(0,0,8'h00,0,1,8'h66,1, 0,0,0,0,0,32'h0D,32'h12345678,8'h43);
        tbl[16] = mk(0,1,8'h00,0,0,0,1, 0,1,32'h55,0,0,32'h09,32'h12345678,8'h43);
        tbl[17] = mk(1,0,8'h04,32'h08,0,0,1, 0,0,0,0,0,32'h01,32'h12345678,8'h43);
        tbl[18] = mk(0,0,8'h00,0,1,8'h77,1, 0,0,0,0,0,32'h05,32'h12345678,8'h43);
        tbl[19] = mk(0,1,8'h00,0,1,8'h88,1, 0,1,32'h77,0,0,32'h05,32'h12345678,8'h43);
        tbl[20] = mk(0,1,8'h00,0,0,0,1, 0,1,32'h88,0,0,32'h01,32'h12345678,8'h43);

        idle_in();
        ifc.tx_ready = 1;
        repeat (2) @(negedge clk);
        chk("rst tx_valid", 32'(ifc.tx_valid), 0);
        chk("rst csr", ifc.io_uart_csr_reg, 32'h1);
        chk("rst gpio", ifc.io_gpio_io_reg, 0);
        chk("rst uio", ifc.io_uart_io_reg, 0);
        chk("rst rvalid", 32'(ifc.io_rvalid), 0);
        chk("rst rdata", ifc.io_rdata, 0);
        chk("rst stall", 32'(ifc.io_stall), 0);
        rst = 1;
        @(negedge clk);

        for (int i = 0; i < 21; i++) begin
            ifc.io_we = tbl[i].we; ifc.io_re = tbl[i].re;
            ifc.io_addr = tbl[i].addr; ifc.io_wdata = tbl[i].wdata;
            ifc.rx_valid = tbl[i].rxv; ifc.rx_data = tbl[i].rxd;
            ifc.tx_ready = tbl[i].txr;
            #1;
            chk($sformatf("v%0d stall", i), 32'(ifc.io_stall), 32'(tbl[i].e_stall));
            @(negedge clk);
            chk($sformatf("v%0d rvalid", i), 32'(ifc.io_rvalid), 32'(tbl[i].e_rvalid));
            if (tbl[i].e_rvalid)
                chk($sformatf("v%0d rdata", i), ifc.io_rdata, tbl[i].e_rdata);
            chk($sformatf("v%0d tx_valid", i), 32'(ifc.tx_valid), 32'(tbl[i].e_txv));
            if (tbl[i].e_txv)
                chk($sformatf("v%0d tx_data", i), 32'(ifc.tx_data), 32'(tbl[i].e_txd));
            chk($sformatf("v%0d csr", i), ifc.io_uart_csr_reg, tbl[i].e_csr);
            chk($sformatf("v%0d gpio", i), ifc.io_gpio_io_reg, tbl[i].e_gpio);
            chk($sformatf("v%0d uio", i), ifc.io_uart_io_reg, {24'h0, tbl[i].e_uio});
        end
        idle_in();

        // Backpressure: SEND holds A1, FIFO fills with A2..A5, A6 stalls
        exp3 = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
        txq.delete();
        ifc.tx_ready = 0;
        for (int i = 0; i < 5; i++) wr_byte(exp3[i]);
        chk("t3 csr full", ifc.io_uart_csr_reg, 32'hC2);
        chk("t3 tx_valid", 32'(ifc.tx_valid), 1);
        chk("t3 tx_data", 32'(ifc.tx_data), 32'hA1);
        ifc.io_we = 1; ifc.io_addr = 8'h00; ifc.io_wdata = 32'hA6;
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("t3 stall hold%0d", i), 32'(ifc.io_stall), 1);
            @(negedge clk);
        end
        chk("t3 uio held", ifc.io_uart_io_reg, 32'hA5);
        ifc.tx_ready = 1;
        #1 chk("t3 stall handshake", 32'(ifc.io_stall), 1);
        @(negedge clk);
        ifc.tx_ready = 0;
        #1 chk("t3 stall pop", 32'(ifc.io_stall), 1);
        @(negedge clk);
        #1 chk("t3 stall release", 32'(ifc.io_stall), 0);
        @(negedge clk);
        idle_in();
        chk("t3 uio A6", ifc.io_uart_io_reg, 32'hA6);
        chk("t3 csr refill", ifc.io_uart_csr_reg, 32'hC2);
        chk("t3 tx_data A2", 32'(ifc.tx_data), 32'hA2);
        ifc.tx_ready = 1;
        done = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            if (ifc.io_uart_csr_reg == 32'h1 && !ifc.tx_valid) done = 1;
        end
        chk("t3 drain done", 32'(done), 1);
        chk("t3 byte count", 32'(txq.size()), 32'd6);
        for (int i = 0; i < 6 && i < txq.size(); i++)
            chk($sformatf("t3 byte%0d", i), 32'(txq[i]), 32'(exp3[i]));

        // Reset mid-SEND with two bytes queued
        ifc.tx_ready = 0;
        wr_byte(8'hB1);
        wr_byte(8'hB2);
        wr_byte(8'hB3);
        idle_in();
        chk("t5 csr pre", ifc.io_uart_csr_reg, 32'hA0);
        chk("t5 tx_valid pre", 32'(ifc.tx_valid), 1);
        txq.delete();
        #2 rst = 0;
        #1;
        chk("t5 tx_valid async", 32'(ifc.tx_valid), 0);
        chk("t5 csr in rst", ifc.io_uart_csr_reg, 32'h1);
        chk("t5 gpio in rst", ifc.io_gpio_io_reg, 0);
        chk("t5 uio in rst", ifc.io_uart_io_reg, 0);
        @(negedge clk);
        rst = 1;
        ifc.tx_ready = 1;
        repeat (10) @(negedge clk);
        chk("t5 csr after", ifc.io_uart_csr_reg, 32'h1);
        chk("t5 no tx", 32'(txq.size()), 0);
        chk("t5 tx_valid after", 32'(ifc.tx_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", ncmp, nfail);
        $finish;
    end
endmodule
